// File: rtl/aes_spi_loader.sv
// aes_spi_loader: serial responder loading the AES block and key.
// Ports: clk, rst (async, high); cs_data/cs_key (active-low selects);
// mosi (MSB first); miso_data/miso_key (shift register MSB loopback);
// data_out/key_out (last full words); data_valid/key_valid (1-cycle);
// start (1-cycle, block and key both pending); proto_err (sticky).
module aes_spi_loader #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_data,
    input  logic              cs_key,
    input  logic              mosi,
    output logic              miso_data,
    output logic              miso_key,
    output logic [DATA_W-1:0] data_out,
    output logic [KEY_W-1:0]  key_out,
    output logic              data_valid,
    output logic              key_valid,
    output logic              start,
    output logic              proto_err
);

    localparam int DCW = $clog2(DATA_W) + 1;
    localparam int KCW = $clog2(KEY_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RX_DATA,
        RX_KEY,
        ERR
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] dsh;
    logic [KEY_W-1:0]  ksh;
    logic [DCW-1:0]    dcnt;
    logic [KCW-1:0]    kcnt;
    logic              dpend;
    logic              kpend;

    logic              both_low;
    logic              sh_d;
    logic              sh_k;
    logic              d_last;
    logic              k_last;
    logic [DATA_W-1:0] dnext;
    logic [KEY_W-1:0]  knext;

    assign both_low = !cs_data && !cs_key;

    // A channel shifts on any edge its select is low, starting with
    // the edge that leaves IDLE; ERR never shifts.
    assign sh_d = !cs_data && cs_key &&
                  (state == IDLE || state == RX_DATA);
    assign sh_k = !cs_key && cs_data &&
                  (state == IDLE || state == RX_KEY);

    assign d_last = (dcnt == DCW'(DATA_W - 1));
    assign k_last = (kcnt == KCW'(KEY_W - 1));
    assign dnext  = {dsh[DATA_W-2:0], mosi};
    assign knext  = {ksh[KEY_W-2:0], mosi};

    assign miso_data = dsh[DATA_W-1];
    assign miso_key  = ksh[KEY_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dsh        <= '0;
            ksh        <= '0;
            dcnt       <= '0;
            kcnt       <= '0;
            dpend      <= 1'b0;
            kpend      <= 1'b0;
            data_out   <= '0;
            key_out    <= '0;
            data_valid <= 1'b0;
            key_valid  <= 1'b0;
            start      <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            key_valid  <= 1'b0;
            start      <= 1'b0;

            if (both_low) begin
                state     <= ERR;
                proto_err <= 1'b1;
                dcnt      <= '0;
                kcnt      <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!cs_data)
                            state <= RX_DATA;
                        else if (!cs_key)
                            state <= RX_KEY;
                    end
                    RX_DATA: begin
                        // Abort drops the partial word count only.
                        if (cs_data) begin
                            state <= IDLE;
                            dcnt  <= '0;
                        end
                    end
                    RX_KEY: begin
                        if (cs_key) begin
                            state <= IDLE;
                            kcnt  <= '0;
                        end
                    end
                    ERR: begin
                        if (cs_data && cs_key)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (sh_d) begin
                dsh <= dnext;
                if (d_last) begin
                    data_out   <= dnext;
                    data_valid <= 1'b1;
                    dcnt       <= '0;
                    if (kpend) begin
                        start <= 1'b1;
                        kpend <= 1'b0;
                        dpend <= 1'b0;
                    end else begin
                        dpend <= 1'b1;
                    end
                end else begin
                    dcnt <= dcnt + DCW'(1);
                end
            end

            if (sh_k) begin
                ksh <= knext;
                if (k_last) begin
                    key_out   <= knext;
                    key_valid <= 1'b1;
                    kcnt      <= '0;
                    if (dpend) begin
                        start <= 1'b1;
                        dpend <= 1'b0;
                        kpend <= 1'b0;
                    end else begin
                        kpend <= 1'b1;
                    end
                end else begin
                    kcnt <= kcnt + KCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_spi_loader.sv
// tb_aes_spi_loader: randomized scoreboard bench for aes_spi_loader.
// Bit-stream history model; monitor pops expectations at negedge+2.
module tb_aes_spi_loader;

    localparam int DW = 128;
    localparam int KW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_data;
    logic          cs_key;
    logic          mosi;
    logic          miso_data;
    logic          miso_key;
    logic [DW-1:0] data_out;
    logic [KW-1:0] key_out;
    logic          data_valid;
    logic          key_valid;
    logic          start;
    logic          proto_err;

    always #5 clk = ~clk;

    aes_spi_loader #(.DATA_W(DW), .KEY_W(KW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_data    (cs_data),
        .cs_key     (cs_key),
        .mosi       (mosi),
        .miso_data  (miso_data),
        .miso_key   (miso_key),
        .data_out   (data_out),
        .key_out    (key_out),
        .data_valid (data_valid),
        .key_valid  (key_valid),
        .start      (start),
        .proto_err  (proto_err)
    );

    typedef struct {
        logic [255:0] w;
        bit           st;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   hist_d[$];
    bit   hist_k[$];
    int   cnt_d;
    int   cnt_k;
    bit   pend_d;
    bit   pend_k;
    exp_t dq[$];
    exp_t kq[$];
    bit   mq_d[$];
    bit   mq_k[$];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        hist_d.delete();
        hist_k.delete();
        for (int i = 0; i < DW; i++) hist_d.push_back(1'b0);
        for (int i = 0; i < KW; i++) hist_k.push_back(1'b0);
        cnt_d  = 0;
        cnt_k  = 0;
        pend_d = 1'b0;
        pend_k = 1'b0;
        dq.delete();
        kq.delete();
        mq_d.delete();
        mq_k.delete();
    endtask

    // One serial bit on a channel; the model tracks the full bit
    // history, so loopback is the bit W positions back and a finished
    // word is the last W bits of the stream.
    task automatic bit_x(input bit ch, input bit b);
        exp_t e;
        @(negedge clk);
        mosi = b;
        if (!ch) begin
            cs_data = 1'b0;
            cs_key  = 1'b1;
            mq_d.push_back(hist_d[hist_d.size() - DW]);
            hist_d.push_back(b);
            if (hist_d.size() > 600) void'(hist_d.pop_front());
            cnt_d++;
            if (cnt_d == DW) begin
                cnt_d = 0;
                e.w = '0;
                for (int i = 0; i < DW; i++)
                    e.w = {e.w[254:0], hist_d[hist_d.size() - DW + i]};
                e.st = pend_k;
                if (pend_k) begin
                    pend_k = 1'b0;
                    pend_d = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
                dq.push_back(e);
            end
        end else begin
            cs_key  = 1'b0;
            cs_data = 1'b1;
            mq_k.push_back(hist_k[hist_k.size() - KW]);
            hist_k.push_back(b);
            if (hist_k.size() > 600) void'(hist_k.pop_front());
            cnt_k++;
            if (cnt_k == KW) begin
                cnt_k = 0;
                e.w = '0;
                for (int i = 0; i < KW; i++)
                    e.w = {e.w[254:0], hist_k[hist_k.size() - KW + i]};
                e.st = pend_d;
                if (pend_d) begin
                    pend_d = 1'b0;
                    pend_k = 1'b0;
                end else begin
                    pend_k = 1'b1;
                end
                kq.push_back(e);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        cs_data = 1'b1;
        cs_key  = 1'b1;
        mosi    = 1'b0;
        cnt_d   = 0;
        cnt_k   = 0;
    endtask

    task automatic both_low();
        @(negedge clk);
        cs_data = 1'b0;
        cs_key  = 1'b0;
        mosi    = 1'($urandom);
        cnt_d   = 0;
        cnt_k   = 0;
    endtask

    task automatic xfer(input bit ch, input int n,
                        input logic [511:0] v);
        for (int i = 0; i < n; i++) bit_x(ch, v[n - 1 - i]);
        idle();
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " data_out"}, data_out, '0);
        chk({tag, " key_out"}, key_out, '0);
        chk({tag, " data_valid"}, data_valid, '0);
        chk({tag, " key_valid"}, key_valid, '0);
        chk({tag, " start"}, start, '0);
        chk({tag, " proto_err"}, proto_err, '0);
        chk({tag, " miso_data"}, miso_data, '0);
        chk({tag, " miso_key"}, miso_key, '0);
    endtask

    // Monitor: sampled mid low phase, away from the rising edge.
    initial begin
        exp_t e;
        bit   b;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b1) begin
                if (mq_d.size() > 0) begin
                    b = mq_d.pop_front();
                    chk("miso_data", miso_data, b);
                end
                if (mq_k.size() > 0) begin
                    b = mq_k.pop_front();
                    chk("miso_key", miso_key, b);
                end
                if (data_valid) begin
                    if (dq.size() == 0) begin
                        chk("spurious data_valid", 1'b1, 1'b0);
                    end else begin
                        e = dq.pop_front();
                        chk("data_out", data_out, e.w);
                        chk("start w/ data", start, e.st);
                    end
                end
                if (key_valid) begin
                    if (kq.size() == 0) begin
                        chk("spurious key_valid", 1'b1, 1'b0);
                    end else begin
                        e = kq.pop_front();
                        chk("key_out", key_out, e.w);
                        chk("start w/ key", start, e.st);
                    end
                end
                if (start && !data_valid && !key_valid)
                    chk("lone start", start, 1'b0);
            end
        end
    end

    initial begin
        logic [511:0] v;
        logic [127:0] blk0;
        logic [255:0] key0;
        logic [127:0] blk1;
        bit           ch;
        int           w;
        int           n;
        int           sel;

        blk0 = 128'h00112233445566778899aabbccddeeff;
        key0 = 256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
        blk1 = 128'h8ea2b7ca516745bfeafc49904b496089;

        rst     = 1'b1;
        cs_data = 1'b1;
        cs_key  = 1'b1;
        mosi    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        idle();

        xfer(1'b0, DW, {384'd0, blk0});
        chk("block load", data_out, blk0);

        xfer(1'b1, KW, {256'd0, key0});
        chk("key load", key_out, key0);

        xfer(1'b0, DW, {384'd0, blk1});
        chk("loopback reload", data_out, blk1);

        v = rnd512();
        xfer(1'b0, 40, v);
        idle();
        chk("abort keeps data_out", data_out, blk1);
        v = rnd512();
        xfer(1'b0, DW, v);
        chk("load after abort", data_out, v[127:0]);

        for (int i = 0; i < 20; i++) bit_x(1'b0, 1'($urandom));
        both_low();
        idle();
        idle();
        chk("proto_err set", proto_err, 1'b1);
        v = rnd512();
        xfer(1'b0, DW, v);
        chk("load after err", data_out, v[127:0]);
        chk("proto_err sticky", proto_err, 1'b1);

        v = rnd512();
        xfer(1'b0, 2 * DW, v);
        chk("over-length word 2", data_out, v[127:0]);

        for (int t = 0; t < 25; t++) begin
            ch  = 1'($urandom);
            w   = ch ? KW : DW;
            sel = int'($urandom_range(0, 3));
            if (sel == 2)
                n = int'($urandom_range(1, w - 1));
            else if (sel == 3)
                n = w + int'($urandom_range(1, w - 1));
            else
                n = w;
            xfer(ch, n, rnd512());
            repeat ($urandom_range(0, 2)) idle();
        end
        chk("proto_err after random", proto_err, 1'b1);

        for (int i = 0; i < 60; i++) bit_x(1'b0, 1'($urandom));
        #3;
        rst = 1'b1;
        #1;
        chk_zero("mid reset");
        model_reset();
        @(negedge clk);
        cs_data = 1'b1;
        cs_key  = 1'b1;
        rst     = 1'b0;
        idle();
        v = rnd512();
        xfer(1'b0, DW, v);
        chk("load after reset", data_out, v[127:0]);
        v = rnd512();
        xfer(1'b1, KW, v);
        chk("key after reset", key_out, v[255:0]);

        repeat (3) idle();
        checks++;
        if (dq.size() + kq.size() + mq_d.size() + mq_k.size() != 0) begin
            errors++;
            $display("FAIL drain: leftover %0d/%0d/%0d/%0d expected 0",
                     dq.size(), kq.size(), mq_d.size(), mq_k.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_spi_loader.md
Name: aes_spi_loader

Overview:
- SPI-style serial responder that loads the AES core's plaintext/ciphertext block and cipher key.
- An external initiator drives the link: it changes mosi on the falling edge of clk and samples miso on the rising edge. Chip selects are active-low: cs_data selects the block channel, cs_key selects the key channel.
- The block deserialises MSB-first into parallel registers and loops the previous register contents back on the matching miso line.
- When both a block and a key have been received, it issues a one-cycle start pulse to the AES datapath.

Parameters:
- DATA_W, 128, block width in bits.
- KEY_W, 256, key width in bits (Nk*32; legal values 128, 192, 256).

Ports:
- clk  in  1  system clock, shared with the serial link.
- rst  in  1  reset.
- cs_data  in  1  active-low select, block channel.
- cs_key  in  1  active-low select, key channel.
- mosi  in  1  serial data in, MSB first.
- miso_data  out  1  MSB of the block shift register.
- miso_key  out  1  MSB of the key shift register.
- data_out  out  DATA_W  last complete block.
- key_out  out  KEY_W  last complete key.
- data_valid  out  1  one-cycle pulse when a block completes.
- key_valid  out  1  one-cycle pulse when a key completes.
- start  out  1  one-cycle pulse when both a block and a key are pending.
- proto_err  out  1  sticky: both selects seen low together.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, every register, output and counter is 0, and the FSM goes to IDLE.
- FSM states: IDLE, RX_DATA, RX_KEY, ERR. All transitions are evaluated on the rising edge of clk.
  - IDLE -> RX_DATA when cs_data=0 and cs_key=1.
  - IDLE -> RX_KEY when cs_key=0 and cs_data=1.
  - Any state -> ERR when cs_data=0 and cs_key=0 on the same edge. ERR sets proto_err and clears both bit counters. No shifting occurs in that cycle.
  - ERR -> IDLE when both selects are high. proto_err stays 1 until rst.
  - RX_DATA -> IDLE when cs_data goes high; likewise RX_KEY -> IDLE when cs_key goes high.
- Shifting: every rising edge where the channel's select is low (including the edge that leaves IDLE) does:
  - shift register <= {shift[W-2:0], mosi};
  - channel counter increments.
  - Counter width is clog2(W)+1.
- Loopback: miso_x is the registered MSB of the shift register. After W shifts the initiator has received the previous W-bit contents, in order.
- Completion: on the edge that samples bit W:
  - data_out/key_out <= the new shift value (the W-1 prior bits plus mosi);
  - x_valid = 1 for exactly the following cycle;
  - the counter wraps to 0;
  - the channel's pending flag is set.
- Over-length burst: a select held low past W clocks keeps shifting, and every further W bits produces another completion.
- Abort: a select deasserted mid-word clears the counter and discards the partial word for the output register. data_out/key_out are unchanged. The shift register keeps its partially shifted contents.
- Start:
  - Asserted for one cycle, on the same cycle as the completing x_valid, when the other channel's pending flag is already set. Both pending flags are then cleared.
  - A second block arriving before any key overwrites data_out and does not pulse start.
- Reset mid-transfer discards everything; the next transfer begins at bit 0.
- Latency: data_out is visible 1 cycle after the last bit's sampling edge.

Test Plan:
- Block load: reset, then cs_data low for 128 clocks shifting 00112233445566778899aabbccddeeff -> data_out equals that value. data_valid is high for 1 cycle. miso_data streams 128 zeros. start stays 0.
- Key load with start: after the block load, cs_key low for 256 clocks shifting 000102…1e1f -> key_out matches. key_valid and start pulse together for 1 cycle. miso_key streams zeros.
- Loopback: reload the block with 8ea2b7ca516745bfeafc49904b496089 -> miso_data returns 00112233445566778899aabbccddeeff MSB first. data_out updates to the new value.
- Abort: cs_data high after 40 bits -> no data_valid and data_out unchanged. A following full 128-bit load completes normally.
- Protocol error: drop both selects on the same edge -> proto_err=1, no shift, counters 0. proto_err stays 1 after the selects rise and clears only on rst.
- Over-length and reset: cs_data held low for 256 clocks -> 2 data_valid pulses, data_out equals the second word. Asserting rst mid-stream zeroes all outputs immediately.
